// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Frame config sanitising lives here so the serializer and any checker agree on it.
package uart_pkg;

    localparam int unsigned MIN_BYTE_SIZE    = 5;
    localparam int unsigned MAX_BYTE_SIZE    = 9;
    localparam int unsigned MIN_CLK_PER_BAUD = 2;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b01,
        PARITY_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        BREAK_MARK
    } tx_state_e;

    function automatic logic [3:0] clamp_byte_size(input logic [3:0] size);
        if (size < 4'(MIN_BYTE_SIZE)) return 4'(MIN_BYTE_SIZE);
        if (size > 4'(MAX_BYTE_SIZE)) return 4'(MAX_BYTE_SIZE);
        return size;
    endfunction

    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PARITY_EVEN;
            2'b10:   return PARITY_ODD;
            default: return PARITY_NONE;
        endcase
    endfunction

    function automatic logic [8:0] data_mask(input logic [3:0] size);
        logic [8:0] m;
        m = '0;
        for (int i = 0; i < 9; i++) begin
            m[i] = (i < int'(size));
        end
        return m;
    endfunction

    // Bits per frame: start + data + optional parity + stop bits (at most 13).
    function automatic logic [3:0] frame_bits(input logic [3:0] size, input parity_e pmode,
                                              input logic two_stop);
        return 4'd1 + size + {3'b000, pmode != PARITY_NONE} + (two_stop ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered read data, full/empty flags and occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module uart_fifo #(
    parameter int unsigned Depth      = 16,
    parameter int unsigned Width      = 9,
    parameter int unsigned LevelWidth = $clog2(Depth) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [Width-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [Width-1:0]      rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [LevelWidth-1:0] level_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [Width-1:0]      mem_q [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [LevelWidth-1:0] level_q;
    logic [Width-1:0]      rd_data_q;
    logic                  do_wr;
    logic                  do_rd;

    assign full_o    = (level_q == LevelWidth'(Depth));
    assign empty_o   = (level_q == '0);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign level_o   = level_q;
    assign rd_data_o = rd_data_q;

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            end
            if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + PtrWidth'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LevelWidth'(1);
                2'b01:   level_q <= level_q - LevelWidth'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO in front of a serializer with per-frame config,
// CTS gating and break generation. txd and tx_busy lag the FSM state by one cycle.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned BAUD_WIDTH  = 16,
    parameter int unsigned LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [BAUD_WIDTH-1:0]  clk_per_baud,
    input  logic [3:0]             byte_size,
    input  logic [1:0]             parity_mode,
    input  logic [1:0]             stop_bits,
    input  logic                   use_cts,
    input  logic                   cts,
    input  logic                   send_break,
    output logic                   txd,
    output logic                   tx_busy,
    output logic [LEVEL_WIDTH-1:0] fifo_level
);

    tx_state_e             state_q, state_d;
    logic [BAUD_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [8:0]            data_q, data_d;
    logic                  par_bit_q, par_bit_d;
    logic                  brk_min_q, brk_min_d;
    logic [BAUD_WIDTH-1:0] cpb_q;
    logic [3:0]            bsize_q;
    parity_e               pmode_q;
    logic                  two_stop_q;
    logic                  txd_q, txd_d;
    logic                  busy_q;

    logic                  latch_cfg;
    logic                  pop;
    logic                  baud_tick;
    logic                  brk_last;
    logic [BAUD_WIDTH-1:0] cpb_in;
    logic [8:0]            fifo_rd_data;
    logic [8:0]            payload;
    logic                  fifo_full;
    logic                  fifo_empty;

    uart_fifo #(
        .Depth      (FIFO_DEPTH),
        .Width      (9),
        .LevelWidth (LEVEL_WIDTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_valid),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign wr_ready  = !fifo_full;
    assign txd       = txd_q;
    assign tx_busy   = busy_q;
    assign cpb_in    = (clk_per_baud < BAUD_WIDTH'(MIN_CLK_PER_BAUD)) ?
                       BAUD_WIDTH'(MIN_CLK_PER_BAUD) : clk_per_baud;
    assign baud_tick = (cnt_q == '0);
    assign pop       = (state_q == IDLE) && !send_break && !fifo_empty && (!use_cts || cts);
    assign payload   = fifo_rd_data & data_mask(bsize_q);
    assign brk_last  = baud_tick &&
                       (bit_cnt_q == frame_bits(bsize_q, pmode_q, two_stop_q) - 4'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = baud_tick ? cpb_q - BAUD_WIDTH'(1) : cnt_q - BAUD_WIDTH'(1);
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        brk_min_d = brk_min_q;
        latch_cfg = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (send_break) begin
                    state_d   = BREAK;
                    latch_cfg = 1'b1;
                    cnt_d     = cpb_in - BAUD_WIDTH'(1);
                    bit_cnt_d = '0;
                    brk_min_d = 1'b0;
                end else if (pop) begin
                    state_d   = START;
                    latch_cfg = 1'b1;
                    cnt_d     = cpb_in - BAUD_WIDTH'(1);
                end
            end
            START: begin
                // Registered FIFO read data is valid from the first START cycle onwards.
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    data_d    = payload;
                    par_bit_d = (^payload) ^ (pmode_q == PARITY_ODD);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    data_d = data_q >> 1;
                    if (bit_cnt_q == bsize_q - 4'd1) begin
                        state_d   = (pmode_q != PARITY_NONE) ? PARITY : STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (two_stop_q && bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BREAK: begin
                if (baud_tick) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                // Hold low for at least one full frame, then release as soon as the request drops.
                if ((brk_min_q || brk_last) && !send_break) begin
                    state_d = BREAK_MARK;
                    cnt_d   = cpb_q - BAUD_WIDTH'(1);
                end else if (brk_last) begin
                    brk_min_d = 1'b1;
                end
            end
            BREAK_MARK: begin
                if (baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = data_q[0];
            PARITY:  txd_d = par_bit_q;
            BREAK:   txd_d = 1'b0;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_bit_q  <= 1'b0;
            brk_min_q  <= 1'b0;
            cpb_q      <= BAUD_WIDTH'(MIN_CLK_PER_BAUD);
            bsize_q    <= 4'(MAX_BYTE_SIZE);
            pmode_q    <= PARITY_NONE;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            brk_min_q <= brk_min_d;
            txd_q     <= txd_d;
            busy_q    <= (state_q != IDLE);
            if (latch_cfg) begin
                cpb_q      <= cpb_in;
                bsize_q    <= clamp_byte_size(byte_size);
                pmode_q    <= decode_parity(parity_mode);
                two_stop_q <= (stop_bits == 2'd2);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed self-checking bench for uart_tx_buf; expected bit streams are built from
// hand-specified frame parameters, not from the DUT.
module tb_uart_tx_buf;

    logic        clk;
    logic        rst;
    logic [8:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] clk_per_baud;
    logic [3:0]  byte_size;
    logic [1:0]  parity_mode;
    logic [1:0]  stop_bits;
    logic        use_cts;
    logic        cts;
    logic        send_break;
    logic        txd;
    logic        tx_busy;
    logic [4:0]  fifo_level;

    int n_tests;
    int n_fail;

    uart_tx_buf #(
        .FIFO_DEPTH  (16),
        .BAUD_WIDTH  (16),
        .LEVEL_WIDTH (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .clk_per_baud (clk_per_baud),
        .byte_size    (byte_size),
        .parity_mode  (parity_mode),
        .stop_bits    (stop_bits),
        .use_cts      (use_cts),
        .cts          (cts),
        .send_break   (send_break),
        .txd          (txd),
        .tx_busy      (tx_busy),
        .fifo_level   (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] cpb, input logic [3:0] bs, input logic [1:0] pm,
                           input logic [1:0] sb);
        clk_per_baud = cpb;
        byte_size    = bs;
        parity_mode  = pm;
        stop_bits    = sb;
    endtask

    task automatic write_byte(input logic [8:0] d);
        int waits;
        waits = 0;
        wr_data  = d;
        wr_valid = 1'b1;
        while (!wr_ready && waits < 2000) begin
            waits++;
            tick();
        end
        if (waits >= 2000) chk("write_timeout", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
    endtask

    // Called in the frame's cycle index `skip` (0 = first start-bit cycle); returns in the
    // cycle after the last stop bit and checks that it is an idle cycle.
    task automatic check_frame(input string tag, input logic [8:0] d, input int nbits,
                               input int pmode, input int nstop, input int cpb,
                               input int skip, input int disturb_at);
        logic exp_bits [16];
        logic p;
        int   nb;
        int   bad;
        int   first_bad;
        int   busy_bad;
        exp_bits[0] = 1'b0;
        nb = 1;
        p  = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            exp_bits[nb] = d[i];
            p = p ^ d[i];
            nb++;
        end
        if (pmode == 1) begin
            exp_bits[nb] = p;
            nb++;
        end else if (pmode == 2) begin
            exp_bits[nb] = ~p;
            nb++;
        end
        for (int i = 0; i < nstop; i++) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        bad       = 0;
        first_bad = -1;
        busy_bad  = 0;
        for (int idx = skip; idx < nb * cpb; idx++) begin
            if (idx == disturb_at) begin
                cts = 1'b0;
                set_cfg(16'd7, 4'd5, 2'b11, 2'd0);
            end
            if (txd !== exp_bits[idx / cpb]) begin
                if (first_bad < 0) first_bad = idx;
                bad++;
            end
            if (tx_busy !== 1'b1) busy_bad++;
            tick();
        end
        if (bad != 0) $display("note %s: first bad bit cycle %0d", tag, first_bad);
        chk({tag, "_bits"}, 32'(bad), 32'd0);
        chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "_idle"}, {30'd0, tx_busy, txd}, 32'b01);
    endtask

    initial begin
        int          bad;
        int          stall;
        logic [8:0]  burst [17];

        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        wr_data    = '0;
        wr_valid   = 1'b0;
        use_cts    = 1'b0;
        cts        = 1'b0;
        send_break = 1'b0;
        set_cfg(16'd4, 4'd8, 2'b00, 2'd1);

        // Asynchronous reset, checked before the first clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 8N1, clk_per_baud 4, 0x55: latency, level timing, 40-cycle frame.
        write_byte(9'h055);
        chk("t1_level_after_wr", 32'(fifo_level), 32'd1);
        chk("t1_txd_n1", 32'(txd), 32'd1);
        tick();
        chk("t1_level_after_pop", 32'(fifo_level), 32'd0);
        chk("t1_txd_n1b", 32'(txd), 32'd1);
        tick();
        chk("t1_start_latency", 32'(txd), 32'd0);
        check_frame("t1", 9'h055, 8, 0, 1, 4, 0, -1);

        // 7 bits, odd parity, 2 stop bits; config scrambled mid-frame must not matter.
        set_cfg(16'd4, 4'd7, 2'b10, 2'd2);
        write_byte(9'h003);
        tick();
        tick();
        chk("t2_start", 32'(txd), 32'd0);
        check_frame("t2", 9'h003, 7, 2, 2, 4, 0, 8);

        // clk_per_baud 1 -> 2, byte_size 15 -> 9, even parity.
        set_cfg(16'd1, 4'd15, 2'b01, 2'd1);
        write_byte(9'h1A3);
        tick();
        tick();
        chk("t3_start", 32'(txd), 32'd0);
        check_frame("t3", 9'h1A3, 9, 1, 1, 2, 0, -1);

        // byte_size 0 -> 5, parity 11 -> none, stop_bits 3 -> one; upper data bits ignored.
        set_cfg(16'd3, 4'd0, 2'b11, 2'd3);
        write_byte(9'h1EA);
        tick();
        tick();
        chk("t4_start", 32'(txd), 32'd0);
        check_frame("t4", 9'h1EA, 5, 0, 1, 3, 0, -1);

        // Burst of 17: FIFO fills to 16 while frame 0 is sending, then frames go back to back.
        set_cfg(16'd4, 4'd8, 2'b00, 2'd1);
        stall = 0;
        for (int i = 0; i < 17; i++) begin
            burst[i] = 9'((i * 29 + 3) & 8'hFF);
            wr_data  = burst[i];
            wr_valid = 1'b1;
            while (!wr_ready && stall < 100) begin
                stall++;
                tick();
            end
            tick();
        end
        wr_valid = 1'b0;
        chk("burst_stalls", 32'(stall), 32'd0);
        chk("burst_level_full", 32'(fifo_level), 32'd16);
        chk("burst_wr_ready_low", 32'(wr_ready), 32'd0);
        check_frame("burst0", burst[0], 8, 0, 1, 4, 14, -1);
        for (int i = 1; i < 17; i++) begin
            tick();
            chk("burst_gap", 32'(txd), 32'd0);
            check_frame("burst", burst[i], 8, 0, 1, 4, 0, -1);
        end
        chk("burst_level_empty", 32'(fifo_level), 32'd0);

        // CTS: held off while cts=0, starts after cts rises, survives cts drop mid-frame.
        use_cts = 1'b1;
        cts     = 1'b0;
        write_byte(9'h0A5);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (txd !== 1'b1 || fifo_level !== 5'd1) bad++;
            tick();
        end
        chk("cts_hold", 32'(bad), 32'd0);
        cts = 1'b1;
        tick();
        chk("cts_pre_start", 32'(txd), 32'd1);
        tick();
        chk("cts_start", 32'(txd), 32'd0);
        check_frame("cts", 9'h0A5, 8, 0, 1, 4, 0, 12);
        set_cfg(16'd4, 4'd8, 2'b00, 2'd1);

        // Break pulse with a byte queued: 40 low, 4 mark, one idle cycle, then the byte.
        cts = 1'b0;
        write_byte(9'h03C);
        tick();
        tick();
        chk("brk_queued_hold", 32'(txd), 32'd1);
        send_break = 1'b1;
        cts        = 1'b1;
        tick();
        send_break = 1'b0;
        chk("brk_pre", 32'(txd), 32'd1);
        tick();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (txd !== 1'b0 || tx_busy !== 1'b1) bad++;
            tick();
        end
        chk("brk_low40", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (txd !== 1'b1 || tx_busy !== 1'b1) bad++;
            tick();
        end
        chk("brk_mark4", 32'(bad), 32'd0);
        chk("brk_idle", {30'd0, tx_busy, txd}, 32'b01);
        tick();
        chk("brk_resume_start", 32'(txd), 32'd0);
        check_frame("brk_resume", 9'h03C, 8, 0, 1, 4, 0, -1);
        use_cts = 1'b0;
        cts     = 1'b0;

        // Reset mid-DATA with 3 entries queued.
        for (int i = 0; i < 4; i++) begin
            wr_data  = 9'(8'h11 * (i + 1));
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_rst_level_before", 32'(fifo_level), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
            tick();
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);
        chk("post_rst_level", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
